// File: rtl/bram_sync_dual_port.sv
// True dual-port synchronous RAM, two independent read/write ports on one clock.
// Latency: 1 cycle for both reads and writes; outputs are purely registered.
// Backpressure: none, every port accepts an access on every enabled clock edge.
module bram_sync_dual_port #(
    parameter int RAM_DATA_WIDTH = 8,
    parameter int RAM_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_wr,
    input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
    input  logic [RAM_DATA_WIDTH-1:0] a_data_in,
    output logic [RAM_DATA_WIDTH-1:0] a_data_out,
    input  logic                      b_wr,
    input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
    input  logic [RAM_DATA_WIDTH-1:0] b_data_in,
    output logic [RAM_DATA_WIDTH-1:0] b_data_out
);

    localparam int DEPTH = 1 << RAM_ADDR_WIDTH;

    logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

    // Storage update. Contents survive reset, but writes are dropped while it is held.
    // Port A is applied last so it wins when both ports write the same word.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (b_wr) begin
                mem[b_addr] <= b_data_in;
            end
            if (a_wr) begin
                mem[a_addr] <= a_data_in;
            end
        end
    end

    // Port A output register: write-first, otherwise the pre-edge stored word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_data_out <= '0;
        end else if (a_wr) begin
            a_data_out <= a_data_in;
        end else begin
            a_data_out <= mem[a_addr];
        end
    end

    // Port B output register: write-first, otherwise the pre-edge stored word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_data_out <= '0;
        end else if (b_wr) begin
            b_data_out <= b_data_in;
        end else begin
            b_data_out <= mem[b_addr];
        end
    end

endmodule

// File: tb/tb_bram_sync_dual_port.sv
module tb_bram_sync_dual_port;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          a_wr;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data_in;
    logic [DW-1:0] a_data_out;
    logic          b_wr;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data_in;
    logic [DW-1:0] b_data_out;

    bram_sync_dual_port #(
        .RAM_DATA_WIDTH(DW),
        .RAM_ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_wr       (a_wr),
        .a_addr     (a_addr),
        .a_data_in  (a_data_in),
        .a_data_out (a_data_out),
        .b_wr       (b_wr),
        .b_addr     (b_addr),
        .b_data_in  (b_data_in),
        .b_data_out (b_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one clock edge; a port is only checked when its
    // expected word is defined (written at least once, or a write this edge).
    typedef struct {
        bit            a_chk;
        logic [DW-1:0] a_exp;
        bit            b_chk;
        logic [DW-1:0] b_exp;
        string         tag;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_mem [DEPTH];
    bit            model_known [DEPTH];
    int            vectors = 0;
    int            miscompares = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
        end
    endtask

    // One access on both ports at the next rising edge. The expectation is the
    // write data for a writing port, else the stored word before the edge.
    task automatic cycle(input string tag,
                         input bit aw, input int aa, input int ad,
                         input bit bw, input int ba, input int bd);
        exp_t e;
        @(negedge clk);
        a_wr = aw; a_addr = AW'(aa); a_data_in = DW'(ad);
        b_wr = bw; b_addr = AW'(ba); b_data_in = DW'(bd);
        e.tag   = tag;
        e.a_chk = aw || model_known[aa];
        e.a_exp = aw ? DW'(ad) : model_mem[aa];
        e.b_chk = bw || model_known[ba];
        e.b_exp = bw ? DW'(bd) : model_mem[ba];
        if (bw) begin model_mem[ba] = DW'(bd); model_known[ba] = 1'b1; end
        if (aw) begin model_mem[aa] = DW'(ad); model_known[aa] = 1'b1; end
        sb.push_back(e);
    endtask

    // Monitor: every edge that has a pending expectation is checked just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && sb.size() > 0) begin
                e = sb.pop_front();
                if (e.a_chk) check({e.tag, " a_data_out"}, a_data_out, e.a_exp);
                if (e.b_chk) check({e.tag, " b_data_out"}, b_data_out, e.b_exp);
            end
        end
    end

    initial begin
        int waited;
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
        rst = 1'b0;
        a_wr = 1'b0; a_addr = '0; a_data_in = '0;
        b_wr = 1'b0; b_addr = '0; b_data_in = '0;
        #12;
        check("reset a_data_out", a_data_out, 8'h00);
        check("reset b_data_out", b_data_out, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // Port A write-first then read back
        cycle("a_wr55", 1, 2, 8'h55, 0, 0, 0);
        cycle("a_wrAA", 1, 2, 8'hAA, 0, 0, 0);
        cycle("a_wrBA", 1, 1, 8'hBA, 0, 0, 0);
        cycle("a_rd2",  0, 2, 0,     0, 2, 0);

        // Asynchronous reset with non-zero outputs; writes ignored during reset
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst a_data_out", a_data_out, 8'h00);
        check("async_rst b_data_out", b_data_out, 8'h00);
        a_wr = 1'b1; a_addr = 4'd2; a_data_in = 8'hEE;
        b_wr = 1'b1; b_addr = 4'd1; b_data_in = 8'hEE;
        @(posedge clk);
        #1;
        check("in_rst a_data_out", a_data_out, 8'h00);
        check("in_rst b_data_out", b_data_out, 8'h00);
        @(negedge clk);
        a_wr = 1'b0; b_wr = 1'b0;
        rst = 1'b1;
        cycle("post_rst_rd", 0, 2, 0, 0, 1, 0);

        // Cross-port read of a word being written
        cycle("pre6",     1, 6, 8'h77, 0, 0, 0);
        cycle("cross_N",  1, 6, 8'h3C, 0, 6, 0);
        cycle("cross_N1", 0, 6, 0,     0, 6, 0);

        // Write collision: port A wins storage, each output shows its own data
        cycle("collide",  1, 5, 8'h11, 1, 5, 8'h22);
        cycle("coll_rd",  0, 5, 0,     0, 5, 0);

        // Independent writes at opposite corners, then swapped reads
        cycle("indep_wr", 1, 0, 8'h0F, 1, 15, 8'hF0);
        cycle("indep_rd", 0, 15, 0,    0, 0,  0);

        // Sweep: fill via B, read via A
        for (int k = 0; k < DEPTH; k++) cycle("sweep_wr", 0, 0, 0, 1, k, k ^ 8'hA5);
        for (int k = 0; k < DEPTH; k++) cycle("sweep_rd", 0, k, 0, 0, 0, 0);

        // Random traffic on both ports
        for (int n = 0; n < 400; n++) begin
            cycle("rand",
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 255)));
        end

        @(negedge clk);
        a_wr = 1'b0; b_wr = 1'b0;
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bram_sync_dual_port.md
# bram_sync_dual_port

True dual-port synchronous block RAM with two independent read/write ports (A and B) sharing one clock. It is a generic storage primitive used wherever two agents need simultaneous random access to one memory, e.g. a producer/consumer buffer or a coefficient table. Both ports read and write, each has a registered output, and the block maps onto FPGA block RAM.

## Interface
- RAM_DATA_WIDTH, default 8: width of each word, in bits.
- RAM_ADDR_WIDTH, default 4: address width; depth = 2^RAM_ADDR_WIDTH words.

Ports:
- clk  input  1  single clock for both ports; all sampling is on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears both output registers only.
- a_wr  input  1  port A write enable.
- a_addr  input  RAM_ADDR_WIDTH  port A word address.
- a_data_in  input  RAM_DATA_WIDTH  port A write data.
- a_data_out  output  RAM_DATA_WIDTH  port A registered read data.
- b_wr  input  1  port B write enable.
- b_addr  input  RAM_ADDR_WIDTH  port B word address.
- b_data_in  input  RAM_DATA_WIDTH  port B write data.
- b_data_out  output  RAM_DATA_WIDTH  port B registered read data.

## Operation
- Storage: array of 2^RAM_ADDR_WIDTH words, each RAM_DATA_WIDTH bits. Contents are not reset and are undefined until written.
- Each port acts on every rising clk edge while rst is high. There is no enable other than the write enable.
- Write (x_wr=1): mem[x_addr] <= x_data_in. The port is write-first, so x_data_out <= x_data_in.
- Read (x_wr=0): x_data_out <= mem[x_addr] as held before the edge.
- Cross-port reads use pre-edge contents. If port B reads the address port A writes in the same cycle, b_data_out gets the old word, and vice versa. The new word is visible from the next cycle.
- Write collision (a_wr=b_wr=1, a_addr==b_addr): port A wins and the stored word is a_data_in. Each port's own output still shows its own write data (write-first).
- Both ports reading the same address returns the same word on both outputs.
- Reset: while rst=0, a_data_out and b_data_out are forced to 0 immediately (asynchronous). Writes are ignored while rst=0. Memory contents are kept through reset.
- Every address in 0..2^RAM_ADDR_WIDTH-1 is valid. There is no wrap or out-of-range case.

## Timing
- Read latency is 1 cycle: the address presented before edge N appears on x_data_out after edge N and holds until the next edge.
- Write latency is 1 cycle: data written at edge N can be read back by either port at edge N+1, and appears on the output after edge N+1.
- Outputs are purely registered, with no combinational path from inputs to outputs.
- Reset assertion clears the outputs with no clock edge needed. On release, the first edge with rst=1 performs a normal access. Release is synchronized externally.
- All inputs must be stable around the rising edge of clk.

## Test plan
- Reset: drive rst=0 mid-run with outputs non-zero -> a_data_out=b_data_out=0 at once, without a clock edge. Release, then read address 2 written before reset -> the previous contents, showing memory kept through reset.
- Port A write/read: write 0x55 to address 2, then 0xAA to address 2, then 0xBA to address 1 -> a_data_out shows 0x55, 0xAA, 0xBA one cycle after each edge (write-first). Then read address 2 with a_wr=0 -> 0xAA.
- Cross-port: A writes 0x3C to address 6 at edge N while B reads address 6 -> b_data_out is the old word after N, and 0x3C after N+1.
- Collision: A writes 0x11 and B writes 0x22 to address 5 at the same edge -> a_data_out=0x11 and b_data_out=0x22. Reading address 5 next cycle from either port -> 0x11.
- Independent ports: A writes 0x0F to address 0 while B writes 0xF0 to address 15 in the same cycle. Then A reads 15 and B reads 0 -> a_data_out=0xF0, b_data_out=0x0F.
- Sweep: write address k with value k XOR 0xA5 for all 16 addresses via port B, then read them back via port A -> every value matches, with 1-cycle latency.
